// File: rtl/branch_predictor.sv
// branch_predictor: PT/BHR/BTB direction and target predictor with post-reset table clear and stats
module branch_predictor #(
  parameter int DBITS          = 32,
  parameter int BHR_BITS       = 8,
  parameter int PT_INDEX_BITS  = 8,
  parameter int CTR_BITS       = 2,
  parameter int BTB_INDEX_BITS = 4,
  parameter int MODE           = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic                     lk_valid,
  input  logic [DBITS-1:0]         lk_pc,
  output logic                     lk_taken,
  output logic                     lk_hit,
  output logic [DBITS-1:0]         lk_target,
  output logic [PT_INDEX_BITS-1:0] lk_pt_idx,
  input  logic                     up_valid,
  input  logic [DBITS-1:0]         up_pc,
  input  logic                     up_is_cond,
  input  logic                     up_taken,
  input  logic [DBITS-1:0]         up_target,
  input  logic [PT_INDEX_BITS-1:0] up_pt_idx,
  input  logic                     up_mispredict,
  output logic [BHR_BITS-1:0]      bhr,
  output logic [31:0]              stat_lookups,
  output logic [31:0]              stat_mispredicts
);
  localparam int PT_N = 1 << PT_INDEX_BITS;
  localparam int BTB_N = 1 << BTB_INDEX_BITS;
  localparam int PTR_BITS = PT_INDEX_BITS > BTB_INDEX_BITS ? PT_INDEX_BITS : BTB_INDEX_BITS;
  localparam int TAG_BITS = DBITS - BTB_INDEX_BITS - 2;
  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_next;
  logic [PTR_BITS-1:0] ptr;
  logic [CTR_BITS-1:0] pt [PT_N];
  logic [BTB_N-1:0] btb_valid;
  logic [BTB_N-1:0] btb_jump;
  logic [TAG_BITS-1:0] btb_tag [BTB_N];
  logic [DBITS-1:0] btb_target [BTB_N];
  logic [PT_INDEX_BITS+BHR_BITS-1:0] bhr_wide;
  logic [PT_INDEX_BITS-1:0] bhr_ext, lk_idx;
  logic [BTB_INDEX_BITS-1:0] lk_bi, up_bi;
  logic [CTR_BITS-1:0] ctr, ctr_next;
  logic [BHR_BITS:0] hist_wide;
  logic upd, pt_in, btb_in, unused_ok;
  assign unused_ok = ^up_pc[1:0];
  // Index/tag derivation, lookup outputs and training values
  always_comb begin
    state_next = (state == INIT && &ptr) ? RUN : state;
    ready = state == RUN;
    bhr_wide = {{PT_INDEX_BITS{1'b0}}, bhr};
    bhr_ext = bhr_wide[PT_INDEX_BITS-1:0];
    lk_idx = MODE == 0 ? lk_pc[PT_INDEX_BITS+1:2] : lk_pc[PT_INDEX_BITS+1:2] ^ bhr_ext;
    lk_bi = lk_pc[BTB_INDEX_BITS+1:2];
    up_bi = up_pc[BTB_INDEX_BITS+1:2];
    lk_hit = lk_valid & ready & btb_valid[lk_bi] & (btb_tag[lk_bi] == lk_pc[DBITS-1:BTB_INDEX_BITS+2]);
    lk_taken = lk_hit & (btb_jump[lk_bi] | pt[lk_idx][CTR_BITS-1]);
    lk_target = lk_taken ? btb_target[lk_bi] : lk_pc + DBITS'(4);
    lk_pt_idx = ready ? lk_idx : '0;
    upd = up_valid & ready & reset;
    ctr = pt[up_pt_idx];
    ctr_next = up_taken ? (&ctr ? ctr : ctr + 1'b1) : (|ctr ? ctr - 1'b1 : ctr);
    hist_wide = {bhr, up_taken};
    pt_in = 32'(ptr) < PT_N;
    btb_in = 32'(ptr) < BTB_N;
  end
  // Control state, clear pointer, history and saturating statistics
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= INIT;
      ptr <= '0;
      bhr <= '0;
      stat_lookups <= '0;
      stat_mispredicts <= '0;
    end else begin
      state <= state_next;
      ptr <= state == INIT ? ptr + 1'b1 : ptr;
      bhr <= (upd & up_is_cond) ? hist_wide[BHR_BITS-1:0] : bhr;
      stat_lookups <= stat_lookups + 32'(lk_valid & ready & ~&stat_lookups);
      stat_mispredicts <= stat_mispredicts + 32'(upd & up_mispredict & ~&stat_mispredicts);
    end
  end
  // Pattern table: cleared to weakly not-taken during INIT, trained by conditional resolutions
  always_ff @(posedge clk) begin
    if (state == INIT && pt_in) pt[ptr[PT_INDEX_BITS-1:0]] <= WEAK_NT;
    else if (upd & up_is_cond) pt[up_pt_idx] <= ctr_next;
  end
  // BTB: valid bits cleared during INIT, entries allocated on taken resolutions
  always_ff @(posedge clk) begin
    if (state == INIT && btb_in) btb_valid[ptr[BTB_INDEX_BITS-1:0]] <= 1'b0;
    else if (upd & up_taken) begin
      btb_valid[up_bi] <= 1'b1;
      btb_jump[up_bi] <= ~up_is_cond;
      btb_tag[up_bi] <= up_pc[DBITS-1:BTB_INDEX_BITS+2];
      btb_target[up_bi] <= up_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: bimodal and gshare instances checked against a table-level model plus directed literals
module tb_branch_predictor;
  localparam int N = 256;
  logic clk = 0, reset = 0;
  logic lk_valid = 0, up_valid = 0, up_is_cond = 0, up_taken = 0, up_mispredict = 0;
  logic [31:0] lk_pc = 0, up_pc = 0, up_target = 0;
  logic [7:0] up_pt_idx = 0;
  logic ready0, hit0, taken0, ready1, hit1, taken1;
  logic [31:0] target0, target1, sl0, sl1, sm0, sm1;
  logic [7:0] idx0, idx1, bhr0, bhr1;
  int checks = 0, failures = 0;
  int m_init = N, m_bhr = 0, m_pt [256], m_tag [16];
  bit m_v [16], m_j [16], armed = 0;
  logic [31:0] m_tgt [16], m_sl = 0, m_sm = 0;

  always #5 clk = ~clk;

  branch_predictor #(.MODE(0)) u0 (.clk(clk), .reset(reset), .ready(ready0), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .lk_taken(taken0), .lk_hit(hit0), .lk_target(target0), .lk_pt_idx(idx0), .up_valid(up_valid), .up_pc(up_pc),
    .up_is_cond(up_is_cond), .up_taken(up_taken), .up_target(up_target), .up_pt_idx(up_pt_idx),
    .up_mispredict(up_mispredict), .bhr(bhr0), .stat_lookups(sl0), .stat_mispredicts(sm0));
  branch_predictor #(.MODE(1)) u1 (.clk(clk), .reset(reset), .ready(ready1), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .lk_taken(taken1), .lk_hit(hit1), .lk_target(target1), .lk_pt_idx(idx1), .up_valid(up_valid), .up_pc(up_pc),
    .up_is_cond(up_is_cond), .up_taken(up_taken), .up_target(up_target), .up_pt_idx(up_pt_idx),
    .up_mispredict(up_mispredict), .bhr(bhr1), .stat_lookups(sl1), .stat_mispredicts(sm1));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Model: tables become fully cleared once the N-cycle init countdown expires
  always @(posedge clk) begin
    if (!reset) begin
      armed <= 1;
      m_init <= N;
      m_bhr <= 0;
      m_sl <= 0;
      m_sm <= 0;
    end else if (m_init > 0) begin
      m_init <= m_init - 1;
      if (m_init == 1) begin
        foreach (m_pt[i]) m_pt[i] <= 1;
        foreach (m_v[i]) m_v[i] <= 0;
      end
    end else begin
      if (lk_valid && m_sl != 32'hFFFFFFFF) m_sl <= m_sl + 1;
      if (up_valid) begin
        if (up_mispredict && m_sm != 32'hFFFFFFFF) m_sm <= m_sm + 1;
        if (up_is_cond) begin
          m_pt[up_pt_idx] <= up_taken ? (m_pt[up_pt_idx] == 3 ? 3 : m_pt[up_pt_idx] + 1)
                                      : (m_pt[up_pt_idx] == 0 ? 0 : m_pt[up_pt_idx] - 1);
          m_bhr <= (m_bhr * 2 + int'(up_taken)) % 256;
        end
        if (up_taken) begin
          m_v[(up_pc / 4) % 16] <= 1;
          m_j[(up_pc / 4) % 16] <= !up_is_cond;
          m_tag[(up_pc / 4) % 16] <= int'(up_pc / 64);
          m_tgt[(up_pc / 4) % 16] <= up_target;
        end
      end
    end
  end

  task automatic cmp(input string s, input int mode, input logic r, input logic h, input logic t,
                     input logic [31:0] tg, input logic [7:0] ix, input logic [7:0] bh,
                     input logic [31:0] sl, input logic [31:0] sm);
    int pci, gi, bi;
    bit rdy, eh, et;
    rdy = m_init == 0;
    pci = (lk_pc / 4) % 256;
    gi = mode == 1 ? pci ^ m_bhr : pci;
    bi = (lk_pc / 4) % 16;
    eh = lk_valid && rdy && m_v[bi] && m_tag[bi] == int'(lk_pc / 64);
    et = eh && (m_j[bi] || m_pt[gi] >= 2);
    check({s, "_ready"}, r, rdy);
    check({s, "_hit"}, h, eh);
    check({s, "_taken"}, t, et);
    check({s, "_target"}, tg, et ? m_tgt[bi] : lk_pc + 4);
    check({s, "_pt_idx"}, ix, rdy ? gi : 0);
    check({s, "_bhr"}, bh, m_bhr);
    check({s, "_stat_lk"}, sl, m_sl);
    check({s, "_stat_mp"}, sm, m_sm);
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (armed) begin
      cmp("bimodal", 0, ready0, hit0, taken0, target0, idx0, bhr0, sl0, sm0);
      cmp("gshare", 1, ready1, hit1, taken1, target1, idx1, bhr1, sl1, sm1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic cond, input logic tk, input logic [31:0] tgt,
                     input logic [7:0] ix, input logic mp);
    up_valid = 1; up_pc = pc; up_is_cond = cond; up_taken = tk; up_target = tgt; up_pt_idx = ix; up_mispredict = mp;
    step();
    up_valid = 0; up_mispredict = 0;
  endtask

  task automatic look(input logic [31:0] pc);
    lk_valid = 1; lk_pc = pc;
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready0 && cnt < 400) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    step(); step();
    reset = 1;
    wait_ready(cnt);
    check("init_len", cnt, 256);
    look(32'h100);
    check("cold_hit", hit0, 0);
    check("cold_taken", taken0, 0);
    check("cold_target", target0, 32'h104);
    step(); lk_valid = 0;
    check("cold_stat", sl0, 1);
    for (int i = 0; i < 16; i++) begin
      look(i * 4);
      check("btb_cleared", hit1, 0);
      step(); lk_valid = 0;
    end
    for (int i = 0; i < 3; i++) upd(32'h200, 1, 1, 32'h180, 8'h80, 0);
    look(32'h200);
    check("sat_taken", taken0, 1);
    check("sat_target", target0, 32'h180);
    step(); lk_valid = 0;
    for (int i = 0; i < 3; i++) upd(32'h200, 1, 0, 0, 8'h80, 0);
    look(32'h200);
    check("nt_hit", hit0, 1);
    check("nt_taken", taken0, 0);
    check("nt_target", target0, 32'h204);
    step(); lk_valid = 0;
    for (int i = 7; i >= 0; i--) upd(32'h1000, 1, 1'((8'hA5 >> i) & 1), 32'h1100, 8'h00, 0);
    check("bhr_a5", bhr1, 32'hA5);
    look(32'h40);
    check("gshare_idx", idx1, 32'hB5);
    check("bimodal_idx", idx0, 32'h10);
    step(); lk_valid = 0;
    upd(32'h40, 1, 1, 32'h900, 8'hB5, 0);
    look(32'h40);
    check("idx10_untrained_hit", hit0, 1);
    check("idx10_untrained", taken0, 0);
    step(); lk_valid = 0;
    upd(32'h2D4, 1, 1, 32'hA00, 8'h01, 0);
    look(32'h2D4);
    check("idxb5_trained", taken0, 1);
    check("idxb5_target", target0, 32'hA00);
    step(); lk_valid = 0;
    upd(32'h300, 0, 1, 32'h800, 8'h00, 1);
    check("jal_bhr", bhr0, 32'h97);
    check("jal_mispredict", sm0, 1);
    look(32'h300);
    check("jal_taken", taken0, 1);
    check("jal_target", target0, 32'h800);
    check("jal_taken_gshare", taken1, 1);
    step(); lk_valid = 0;
    reset = 0; step(); reset = 1;
    lk_valid = 1; lk_pc = 32'h300;
    up_valid = 1; up_pc = 32'h300; up_is_cond = 1; up_taken = 1; up_target = 32'h700; up_pt_idx = 8'hC0; up_mispredict = 1;
    for (int i = 0; i < 100; i++) step();
    reset = 0; step(); reset = 1;
    wait_ready(cnt);
    lk_valid = 0; up_valid = 0; up_mispredict = 0;
    check("reinit_len", cnt, 256);
    check("reinit_stat_lk", sl0, 0);
    check("reinit_stat_mp", sm1, 0);
    check("reinit_bhr", bhr1, 0);
    look(32'h300);
    check("reinit_hit", hit0, 0);
    check("reinit_target", target0, 32'h304);
    step(); lk_valid = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised direction and target predictor shared by FE and AGEX. FE does a same-cycle lookup by PC. AGEX sends one resolution update per cycle to train the pattern table (PT), branch history register (BHR) and branch target buffer (BTB). Adds over the previous in-stage tables: a post-reset table-clear sequence, BTB valid bits, bimodal/gshare mode select, a generic saturating-counter width, and performance counters.

## Interface
Parameters:
- DBITS, 32, address/data width
- BHR_BITS, 8, global history length
- PT_INDEX_BITS, 8, log2 PT entries
- CTR_BITS, 2, PT counter width (>=1)
- BTB_INDEX_BITS, 4, log2 BTB entries (direct-mapped)
- MODE, 1, 0 = bimodal, 1 = gshare

Ports:
- clk in 1 — the single clock
- reset in 1 — synchronous, active-low
- ready out 1 — tables initialised; lookups/updates honoured
- lk_valid in 1 — FE lookup request
- lk_pc in DBITS — fetch PC
- lk_taken out 1 — predicted taken
- lk_hit out 1 — BTB tag hit
- lk_target out DBITS — predicted next PC
- lk_pt_idx out PT_INDEX_BITS — PT index used; carried FE→DE→AGEX
- up_valid in 1 — AGEX resolution valid
- up_pc in DBITS — branch PC
- up_is_cond in 1 — 1 = conditional branch, 0 = JAL/JALR
- up_taken in 1 — actual direction
- up_target in DBITS — actual target
- up_pt_idx in PT_INDEX_BITS — lk_pt_idx returned from lookup
- up_mispredict in 1 — AGEX detected misprediction
- bhr out BHR_BITS — current history
- stat_lookups out 32 — honoured lookup count
- stat_mispredicts out 32 — honoured mispredict count

## Operation
- Index and tag fields:
  - pc_idx = pc[PT_INDEX_BITS+1:2].
  - PT index = pc_idx when MODE=0; pc_idx XOR bhr when MODE=1. bhr is zero-extended or truncated to PT_INDEX_BITS.
  - BTB index = pc[BTB_INDEX_BITS+1:2]; tag = pc[DBITS-1:BTB_INDEX_BITS+2].
- BTB entry: valid, tag, target, is_jump.
- States: INIT and RUN.
  - reset low → INIT; clear pointer = 0; bhr = 0; stats = 0; ready = 0.
  - INIT: each cycle, write PT[ptr] = 2^(CTR_BITS-1)-1 (weakly not-taken) and clear BTB[ptr].valid, with each table written only while ptr is in its range. Increment ptr.
  - After ptr = max(2^PT_INDEX_BITS, 2^BTB_INDEX_BITS)-1 has been written, go to RUN.
  - RUN: ready = 1.
- Lookup (combinational, RUN only):
  - lk_hit = lk_valid & ready & BTB.valid & tag match.
  - lk_taken = lk_hit & (is_jump | PT[idx][CTR_BITS-1]).
  - lk_target = lk_taken ? BTB.target : lk_pc+4.
  - When not ready, all lookup outputs are 0 except lk_target = lk_pc+4.
- Update (on clk edge; only when up_valid & ready):
  - Conditional branch: PT[up_pt_idx] increments on taken, decrements on not-taken, saturating at 2^CTR_BITS-1 and 0. bhr = {bhr[BHR_BITS-2:0], up_taken}.
  - JAL/JALR: PT and bhr unchanged.
  - up_taken = 1: write BTB[up_pc index] = {valid=1, tag, up_target, is_jump = ~up_is_cond}.
  - Not-taken: BTB unchanged.
- Stats:
  - stat_lookups += 1 on lk_valid & ready.
  - stat_mispredicts += 1 on up_valid & ready & up_mispredict.
  - Both saturate at 32'hFFFFFFFF.
- Inputs are ignored during INIT.

## Timing
- Lookup has zero latency, combinational from lk_pc and table state.
- Updates become visible to lookups on the cycle after the edge. A same-cycle lookup reads pre-update contents; there is no bypass.
- The lk_pt_idx/up_pt_idx round trip guarantees training uses the index computed with the BHR seen at fetch.
- Reset values: ready = 0, bhr = 0, stats = 0, lk_* = 0 (lk_target = lk_pc+4).
- INIT lasts N = max(2^PT_INDEX_BITS, 2^BTB_INDEX_BITS) cycles after reset deasserts. ready rises on the edge completing the last write.
- Reset asserted mid-INIT or mid-RUN restarts INIT from ptr 0 on the next edge. In-flight updates are dropped.
- Simultaneous lookup and update to the same entry: lookup returns the old value; the update commits.
- PT index wraps modulo 2^PT_INDEX_BITS; the clear pointer never exceeds N-1.

## Test plan
- Reset held 2 cycles then released (defaults) → ready = 0 for exactly 256 cycles, then 1. Every PT entry reads 1; every BTB entry is invalid.
- Cold lookup of PC 0x100 → lk_hit = 0, lk_taken = 0, lk_target = 0x104, stat_lookups = 1.
- MODE=0, conditional at 0x200 resolved taken ×3 to 0x180 → counter goes 1→2→3→3 (saturates). Next lookup gives lk_taken = 1, lk_target = 0x180. Then 3× not-taken → 0; lk_taken = 0 while lk_hit = 1.
- MODE=1, bhr = 8'hA5, lookup PC 0x40 → lk_pt_idx = 0x10 ^ 0xA5 = 0xB5. Update with up_pt_idx = 0xB5 trains entry 0xB5, not 0x10.
- JAL at 0x300 taken to 0x800 → bhr unchanged. Next lookup gives lk_taken = 1, target 0x800, regardless of counter. Concurrent up_mispredict → stat_mispredicts increments by 1.
- Reset pulsed at INIT cycle 100 → ready stays 0 for a full 256 cycles after release. Updates during INIT cause no table or stat change.
